// File: rtl/simple_exec_ctrl_pkg.sv
// simple_definitions: types shared by the simple core.
//   instruction_s : opcode + rd/rs register fields
//   opcode_e      : ADD, SUB, WAIT, NOP (other encodings are treated as NOP)
//   ctrl_state_e  : execution controller states
package simple_definitions;

   localparam int RF_AW = 5;

   typedef enum logic [3:0] {
      NOP  = 4'h0,
      ADD  = 4'h1,
      SUB  = 4'h2,
      WAIT = 4'h3
   } opcode_e;

   typedef struct packed {
      opcode_e           op;
      logic [RF_AW-1:0]  rd;
      logic [RF_AW-1:0]  rs;
   } instruction_s;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      READ  = 3'd2,
      EXEC  = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } ctrl_state_e;

endpackage

// File: rtl/simple_exec_ctrl_alu.sv
// simple_alu: combinational ALU for the simple core.
//   a_i, b_i  : operands (rd value, rs value)
//   ir_i      : current instruction
//   res_o     : result, wraps modulo 2^32
//   wflag_o   : result should be written back to rd
//   stop_o    : WAIT seen, core should halt
module simple_alu
   import simple_definitions::*;
(
   input  logic [31:0]  a_i,
   input  logic [31:0]  b_i,
   input  instruction_s ir_i,
   output logic [31:0]  res_o,
   output logic         wflag_o,
   output logic         stop_o
);

   always_comb begin
      res_o   = '0;
      wflag_o = 1'b0;
      stop_o  = 1'b0;
      case (ir_i.op)
         ADD: begin
            res_o   = a_i + b_i;
            wflag_o = 1'b1;
         end
         SUB: begin
            res_o   = a_i - b_i;
            wflag_o = 1'b1;
         end
         WAIT:    stop_o = 1'b1;
         default: ;  // NOP and unknown opcodes retire without a write
      endcase
   end

endmodule

// File: rtl/simple_exec_ctrl.sv
// simple_exec_ctrl: multi-cycle execution controller of the simple core.
// Runs FETCH -> READ -> EXEC -> WB per instruction, halts on WAIT.
//   clk, n_reset           : clock, async active-low reset
//   start_i, pc_start_i    : start execution (IDLE/HALT only)
//   imem_*                 : instruction fetch handshake (req held until valid)
//   rf_rd/rs_addr_o, *_data_i : combinational register file read port
//   rf_we_o, rf_waddr_o, rf_wdata_o : register file write port
//   pc_o, busy_o, halted_o, instr_count_o : status
module simple_exec_ctrl
   import simple_definitions::*;
#(
   parameter int IMEM_ADDR_W = 10,
   parameter int RF_ADDR_W   = RF_AW
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   start_i,
   input  logic [IMEM_ADDR_W-1:0] pc_start_i,
   output logic                   imem_req_o,
   output logic [IMEM_ADDR_W-1:0] imem_addr_o,
   input  logic                   imem_valid_i,
   input  instruction_s           imem_data_i,
   output logic [RF_ADDR_W-1:0]   rf_rd_addr_o,
   output logic [RF_ADDR_W-1:0]   rf_rs_addr_o,
   input  logic [31:0]            rf_rd_data_i,
   input  logic [31:0]            rf_rs_data_i,
   output logic                   rf_we_o,
   output logic [RF_ADDR_W-1:0]   rf_waddr_o,
   output logic [31:0]            rf_wdata_o,
   output logic [IMEM_ADDR_W-1:0] pc_o,
   output logic                   busy_o,
   output logic                   halted_o,
   output logic [31:0]            instr_count_o
);

   ctrl_state_e            state_q, state_d;
   logic [IMEM_ADDR_W-1:0] pc_q;
   instruction_s           ir_q;
   logic [31:0]            opa_q, opb_q, res_q, cnt_q;
   logic                   wflag_q;

   logic [31:0] alu_res;
   logic        alu_wflag, alu_stop;

   simple_alu u_alu (
      .a_i     (opa_q),
      .b_i     (opb_q),
      .ir_i    (ir_q),
      .res_o   (alu_res),
      .wflag_o (alu_wflag),
      .stop_o  (alu_stop)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALT: if (start_i)      state_d = FETCH;
         FETCH:      if (imem_valid_i) state_d = READ;
         READ:       state_d = EXEC;
         EXEC:       state_d = alu_stop ? HALT : WB;
         WB:         state_d = FETCH;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pc_q    <= '0;
         ir_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         wflag_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, HALT: if (start_i) begin
               pc_q  <= pc_start_i;
               cnt_q <= '0;
            end
            FETCH: if (imem_valid_i) ir_q <= imem_data_i;
            READ: begin
               opa_q <= rf_rd_data_i;
               opb_q <= rf_rs_data_i;
            end
            EXEC: begin
               res_q   <= alu_res;
               wflag_q <= alu_wflag;
               // WAIT retires here; PC stays on the WAIT instruction
               if (alu_stop) cnt_q <= cnt_q + 32'd1;
            end
            WB: begin
               pc_q  <= pc_q + 1'b1;
               cnt_q <= cnt_q + 32'd1;
            end
            default: ;
         endcase
      end
   end

   // Write enable is decoded from the state register so that an async
   // reset removes it immediately.
   assign rf_we_o       = (state_q == WB) && wflag_q;
   assign rf_waddr_o    = ir_q.rd;
   assign rf_wdata_o    = res_q;
   assign rf_rd_addr_o  = ir_q.rd;
   assign rf_rs_addr_o  = ir_q.rs;
   assign imem_req_o    = (state_q == FETCH);
   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign busy_o        = (state_q == FETCH) || (state_q == READ) ||
                          (state_q == EXEC)  || (state_q == WB);
   assign halted_o      = (state_q == HALT);
   assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_simple_exec_ctrl.sv
module tb_simple_exec_ctrl;
   import simple_definitions::*;

   logic               clk = 1'b0;
   logic               n_reset;
   logic               start_i;
   logic [9:0]         pc_start_i;
   logic               imem_req_o;
   logic [9:0]         imem_addr_o;
   logic               imem_valid_i;
   instruction_s       imem_data_i;
   logic [4:0]         rf_rd_addr_o, rf_rs_addr_o;
   logic [31:0]        rf_rd_data_i, rf_rs_data_i;
   logic               rf_we_o;
   logic [4:0]         rf_waddr_o;
   logic [31:0]        rf_wdata_o;
   logic [9:0]         pc_o;
   logic               busy_o, halted_o;
   logic [31:0]        instr_count_o;

   simple_exec_ctrl dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .start_i       (start_i),
      .pc_start_i    (pc_start_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_valid_i  (imem_valid_i),
      .imem_data_i   (imem_data_i),
      .rf_rd_addr_o  (rf_rd_addr_o),
      .rf_rs_addr_o  (rf_rs_addr_o),
      .rf_rd_data_i  (rf_rd_data_i),
      .rf_rs_data_i  (rf_rs_data_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .pc_o          (pc_o),
      .busy_o        (busy_o),
      .halted_o      (halted_o),
      .instr_count_o (instr_count_o)
   );

   always #5 clk = ~clk;

   // memory models
   logic [31:0]  rf [0:31];
   instruction_s imem [0:1023];
   int           stall_n;
   int           wait_cnt;

   assign rf_rd_data_i = rf[rf_rd_addr_o];
   assign rf_rs_data_i = rf[rf_rs_addr_o];
   assign imem_data_i  = imem[imem_addr_o];
   assign imem_valid_i = imem_req_o && (wait_cnt >= stall_n);

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset)                         wait_cnt <= 0;
      else if (imem_req_o && !imem_valid_i) wait_cnt <= wait_cnt + 1;
      else                                  wait_cnt <= 0;
   end

   // scoreboard
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   int total = 0;
   int pass  = 0;
   int nwr   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic instruction_s mk(input opcode_e op, input int rd, input int rs);
      instruction_s i;
      i.op = op;
      i.rd = rd[4:0];
      i.rs = rs[4:0];
      return i;
   endfunction

   // monitor: pops expected writes, updates RF model, checks fetch hold
   initial begin
      logic       prev_req, prev_vld;
      logic [9:0] prev_addr;
      wr_t        e;
      prev_req = 1'b0; prev_vld = 1'b0; prev_addr = '0;
      forever begin
         @(negedge clk);
         if (n_reset && rf_we_o) begin
            nwr++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(rf_waddr_o), 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("waddr", 32'(rf_waddr_o), 32'(e.a));
               chk("wdata", rf_wdata_o, e.d);
            end
            rf[rf_waddr_o] = rf_wdata_o;
         end
         if (prev_req && !prev_vld && imem_req_o)
            chk("fetch_addr_hold", 32'(imem_addr_o), 32'(prev_addr));
         prev_req  = imem_req_o;
         prev_vld  = imem_valid_i;
         prev_addr = imem_addr_o;
      end
   end

   task automatic start_run(input int pc);
      @(negedge clk);
      start_i    = 1'b1;
      pc_start_i = pc[9:0];
      @(negedge clk);
      start_i    = 1'b0;
   endtask

   task automatic run_halt(output int n);
      n = 0;
      while (!halted_o && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int cyc, nw0;
      n_reset = 1'b0; start_i = 1'b0; pc_start_i = '0; stall_n = 0;
      for (int i = 0; i < 1024; i++) imem[i] = mk(NOP, 0, 0);
      for (int i = 0; i < 32; i++) rf[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req",    32'(imem_req_o), 0);
      chk("rst_we",     32'(rf_we_o), 0);
      chk("rst_busy",   32'(busy_o), 0);
      chk("rst_halted", 32'(halted_o), 0);
      chk("rst_pc",     32'(pc_o), 0);
      chk("rst_count",  instr_count_o, 0);
      n_reset = 1'b1;

      // ADD r1,r2 ; WAIT
      rf[1] = 32'd5; rf[2] = 32'd7;
      imem[0] = mk(ADD, 1, 2); imem[1] = mk(WAIT, 0, 0);
      exp_q.push_back('{5'd1, 32'd12});
      start_run(0);
      run_halt(cyc);
      chk("add_cycles", 32'(cyc), 7);
      chk("add_count",  instr_count_o, 2);
      chk("add_pc",     32'(pc_o), 1);
      chk("add_halted", 32'(halted_o), 1);
      chk("add_busy",   32'(busy_o), 0);

      // SUB wrap
      rf[3] = 32'd0; rf[4] = 32'd1;
      imem[0] = mk(SUB, 3, 4);
      exp_q.push_back('{5'd3, 32'hFFFF_FFFF});
      start_run(0);
      run_halt(cyc);
      chk("sub_cycles", 32'(cyc), 7);
      chk("sub_count",  instr_count_o, 2);

      // fetch stall of 3 cycles on every fetch
      stall_n = 3;
      rf[1] = 32'd5; rf[2] = 32'd7;
      imem[0] = mk(ADD, 1, 2);
      exp_q.push_back('{5'd1, 32'd12});
      start_run(0);
      run_halt(cyc);
      chk("stall_cycles", 32'(cyc), 13);
      chk("stall_count",  instr_count_o, 2);
      chk("stall_pc",     32'(pc_o), 1);
      stall_n = 0;

      // NOP at 1023, PC wraps to WAIT at 0
      imem[1023] = mk(NOP, 6, 7); imem[0] = mk(WAIT, 0, 0);
      nw0 = nwr;
      start_run(1023);
      chk("wrap_pc_start", 32'(pc_o), 1023);
      run_halt(cyc);
      chk("wrap_cycles", 32'(cyc), 7);
      chk("nop_writes",  32'(nwr - nw0), 0);
      chk("wrap_pc",     32'(pc_o), 0);
      chk("wrap_count",  instr_count_o, 2);

      // restart from HALT at 8
      imem[8] = mk(WAIT, 0, 0);
      start_run(8);
      chk("restart_count0", instr_count_o, 0);
      chk("restart_req",    32'(imem_req_o), 1);
      chk("restart_addr",   32'(imem_addr_o), 8);
      run_halt(cyc);
      chk("restart_cycles", 32'(cyc), 3);
      chk("restart_count",  instr_count_o, 1);
      chk("restart_pc",     32'(pc_o), 8);

      // reset during WB of an ADD
      rf[1] = 32'd5; rf[2] = 32'd7;
      imem[0] = mk(ADD, 1, 2); imem[1] = mk(WAIT, 0, 0);
      exp_q.push_back('{5'd1, 32'd12});
      start_run(0);
      repeat (3) @(negedge clk);
      chk("wb_we", 32'(rf_we_o), 1);
      #2 n_reset = 1'b0;
      #1;
      chk("abort_we",     32'(rf_we_o), 0);
      chk("abort_req",    32'(imem_req_o), 0);
      chk("abort_busy",   32'(busy_o), 0);
      chk("abort_halted", 32'(halted_o), 0);
      chk("abort_pc",     32'(pc_o), 0);
      chk("abort_count",  instr_count_o, 0);
      @(negedge clk);
      n_reset = 1'b1;
      rf[1] = 32'd5;
      exp_q.push_back('{5'd1, 32'd12});
      start_run(0);
      run_halt(cyc);
      chk("rerun_cycles", 32'(cyc), 7);
      chk("rerun_count",  instr_count_o, 2);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
